// File: rtl/axis_credit_tx.sv
// axis_credit_tx
//   Transmit end of a credit-based stream link. Beats from a local AXI-stream
//   source are forwarded as a registered, valid-only stream (no ready) to a
//   remote receive buffer holding CREDITS slots. The far end returns one credit
//   pulse per slot freed. Holding in-flight beats to the credits on hand
//   replaces a long combinational tready path between distant regions.
//
// Parameters
//   WIDTH    data width in bits
//   CREDITS  far-end buffer slots (1..255); initial and maximum credit count
//   CW       credit counter width (derived)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   s_rx_tdata/tvalid/tready   upstream AXI-stream slave (tready from credit count only)
//   m_tx_tdata/tvalid          registered downstream stream, one-cycle pulse per beat
//   credit_return   one pulse per far-end slot freed (may repeat every cycle)
//   credit_cnt      credits currently held
//   credit_err      sticky credit-overflow flag, cleared only by rst
//
// Optional feature (macro AXIS_CREDIT_TX_STATS_EN)
//   Adds stat_beats (accepted beats) and stat_stalls (cycles with tvalid high
//   and tready low), both 32-bit, reset to 0, wrapping.
module axis_credit_tx #(
  parameter  int WIDTH   = 32,
  parameter  int CREDITS = 2,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_rx_tdata,
  input  logic             s_rx_tvalid,
  output logic             s_rx_tready,
  output logic [WIDTH-1:0] m_tx_tdata,
  output logic             m_tx_tvalid,
  input  logic             credit_return,
  output logic [CW-1:0]    credit_cnt,
`ifdef AXIS_CREDIT_TX_STATS_EN
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_stalls,
`endif
  output logic             credit_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             vld_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;

  // Ready comes only from the registered count, so the upstream handshake
  // never sees a combinational path from the far end or from tvalid.
  assign s_rx_tready = (cnt_q != '0);
  assign accept      = s_rx_tvalid & s_rx_tready;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({accept, credit_return})
      2'b10: cnt_d = cnt_q - CNT_ONE;
      2'b01: begin
        // A return while already full means the far end freed a slot we never
        // filled: saturate and flag it.
        if (cnt_q == CNT_MAX) err_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_ONE;
      end
      default: ; // idle, or accept and return cancel out
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Output stage: valid pulses for exactly one cycle per accepted beat; data
  // holds its last value between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) data_q <= s_rx_tdata;
    end
  end

  assign m_tx_tvalid = vld_q;
  assign m_tx_tdata  = data_q;
  assign credit_cnt  = cnt_q;
  assign credit_err  = err_q;

`ifdef AXIS_CREDIT_TX_STATS_EN
  logic [31:0] beats_q, stalls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (accept)                     beats_q  <= beats_q + 32'd1;
      if (s_rx_tvalid && !s_rx_tready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_axis_credit_tx.sv
module tb_axis_credit_tx;

  localparam int WIDTH   = 32;
  localparam int CREDITS = 2;
  localparam int CW      = $clog2(CREDITS + 1);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] s_rx_tdata;
  logic             s_rx_tvalid;
  logic             s_rx_tready;
  logic [WIDTH-1:0] m_tx_tdata;
  logic             m_tx_tvalid;
  logic             credit_return;
  logic [CW-1:0]    credit_cnt;
  logic             credit_err;
`ifdef AXIS_CREDIT_TX_STATS_EN
  logic [31:0]      stat_beats;
  logic [31:0]      stat_stalls;
`endif

  axis_credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_rx_tdata    (s_rx_tdata),
    .s_rx_tvalid   (s_rx_tvalid),
    .s_rx_tready   (s_rx_tready),
    .m_tx_tdata    (m_tx_tdata),
    .m_tx_tvalid   (m_tx_tvalid),
    .credit_return (credit_return),
    .credit_cnt    (credit_cnt),
`ifdef AXIS_CREDIT_TX_STATS_EN
    .stat_beats    (stat_beats),
    .stat_stalls   (stat_stalls),
`endif
    .credit_err    (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        ret;
    logic        exp_rdy;   // tready before the edge
    logic        exp_tv;    // after the edge
    logic [31:0] exp_td;
    logic [1:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  // Apply one cycle of inputs, check ready before the edge and the registered
  // outputs just after it.
  task automatic step(input vec_t v, input string tag);
    s_rx_tvalid   = v.vld;
    s_rx_tdata    = v.data;
    credit_return = v.ret;
    #1;
    check({tag, ".rdy"}, 32'(s_rx_tready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    check({tag, ".tv"},  32'(m_tx_tvalid), 32'(v.exp_tv));
    check({tag, ".td"},  m_tx_tdata,       v.exp_td);
    check({tag, ".cnt"}, 32'(credit_cnt),  32'(v.exp_cnt));
    check({tag, ".err"}, 32'(credit_err),  32'(v.exp_err));
  endtask

  initial begin
    //           vld  data   ret  rdy tv  td     cnt  err
    vecs[0]  = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 32'hA1, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 32'hA1, 2'd1, 1'b0};
    vecs[4]  = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA2, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'hA2, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hA2, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 32'hB0, 1'b1, 1'b1, 1'b1, 32'hB0, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hB0, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hB0, 2'd2, 1'b1};
    vecs[10] = '{1'b1, 32'hC0, 1'b0, 1'b1, 1'b1, 32'hC0, 2'd1, 1'b1};
    vecs[11] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hC0, 2'd2, 1'b1};

    rst = 1'b1;
    s_rx_tvalid = 1'b0;
    s_rx_tdata = '0;
    credit_return = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.cnt", 32'(credit_cnt),  32'd2);
    check("rst.rdy", 32'(s_rx_tready), 32'd1);
    check("rst.tv",  32'(m_tx_tvalid), 32'd0);
    check("rst.td",  m_tx_tdata,       32'd0);
    check("rst.err", 32'(credit_err),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Error flag stays set across idle cycles.
    s_rx_tvalid = 1'b0;
    credit_return = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sticky%0d.err", i), 32'(credit_err), 32'd1);
      check($sformatf("sticky%0d.cnt", i), 32'(credit_cnt), 32'd2);
    end

    // Asynchronous reset while an output pulse is live.
    s_rx_tvalid = 1'b1;
    s_rx_tdata = 32'hD0;
    @(posedge clk);
    #1;
    s_rx_tvalid = 1'b0;
    check("pre_arst.tv",  32'(m_tx_tvalid), 32'd1);
    check("pre_arst.cnt", 32'(credit_cnt),  32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.tv",  32'(m_tx_tvalid), 32'd0);
    check("arst.cnt", 32'(credit_cnt),  32'd2);
    check("arst.err", 32'(credit_err),  32'd0);
    check("arst.td",  m_tx_tdata,       32'd0);
    check("arst.rdy", 32'(s_rx_tready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Steady stream: return every cycle after the first beat keeps one credit
    // in hand and never drops ready.
    for (int i = 0; i < 100; i++) begin
      s_rx_tvalid   = 1'b1;
      s_rx_tdata    = 32'h1000 + i;
      credit_return = (i != 0);
      #1;
      check($sformatf("strm%0d.rdy", i), 32'(s_rx_tready), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("strm%0d.tv", i),  32'(m_tx_tvalid), 32'd1);
      check($sformatf("strm%0d.td", i),  m_tx_tdata,       32'h1000 + i);
      check($sformatf("strm%0d.cnt", i), 32'(credit_cnt),  32'd1);
    end
    s_rx_tvalid = 1'b0;
    credit_return = 1'b0;
    @(posedge clk);
    #1;
    check("strm_end.tv",  32'(m_tx_tvalid), 32'd0);
    check("strm_end.err", 32'(credit_err),  32'd0);

`ifdef AXIS_CREDIT_TX_STATS_EN
    // Fresh reset, then accept, accept, stall.
    rst = 1'b1;
    #1;
    check("stat.rst_beats",  stat_beats,  32'd0);
    check("stat.rst_stalls", stat_stalls, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_rx_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_rx_tvalid = 1'b0;
    check("stat.beats",  stat_beats,  32'd2);
    check("stat.stalls", stat_stalls, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
